div_uart_seq: RTL

Frame sequencer between `uart_rx`, the 16-bit `division` core and `uart_tx`. It collects a 4-byte request frame, checks the divisor, starts the divider and waits for its result. It then serialises a 4-byte response frame through the transmitter, using a ready handshake. The sequencer also enforces inter-byte and divider timeouts, reports divide-by-zero and overrun, and replaces the ad-hoc counters in the top level.

---
 rtl/div_uart_seq_if.sv | 25 ++
 rtl/div_uart_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/div_uart_seq_if.sv
// Handshake bundle between the frame sequencer, the UART pair and the divider core.
// The master modport is the sequencer's view; the slave modport is the surrounding logic.
interface div_uart_seq_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        div_start;
    logic [15:0] div_dividend;
    logic [15:0] div_divisor;
    logic [15:0] div_quot;
    logic [15:0] div_rem;
    logic        div_done;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        input  rx_data, rx_valid, div_quot, div_rem, div_done, tx_ready,
        output div_start, div_dividend, div_divisor, tx_data, tx_valid
    );

    modport slave (
        output rx_data, rx_valid, div_quot, div_rem, div_done, tx_ready,
        input  div_start, div_dividend, div_divisor, tx_data, tx_valid
    );
endinterface

// File: rtl/div_uart_seq.sv
// Frame sequencer: collects a 4-byte divide request from the UART receiver, runs the
// divider (or short-circuits a zero divisor) and streams the 4-byte result to the UART
// transmitter. Inter-byte and divider timeouts abort the frame; bytes arriving while a
// frame is being processed are dropped and flagged. All outputs are registered.
module div_uart_seq #(
    parameter int unsigned RX_TIMEOUT  = 104160,
    parameter int unsigned DIV_TIMEOUT = 256
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    div_uart_seq_if.master        bus,
    output logic                  busy,
    output logic                  err_timeout,
    output logic                  err_div0,
    output logic                  rx_overrun
);

    localparam int unsigned TMAX = (RX_TIMEOUT > DIV_TIMEOUT) ? RX_TIMEOUT : DIV_TIMEOUT;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] RX_LAST  = TW'(RX_TIMEOUT - 1);
    localparam logic [TW-1:0] DIV_LAST = TW'(DIV_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle, StRecv, StCheck, StStart, StWait, StSend, StTxWait
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     byte_cnt_q, byte_cnt_d;
    logic [2:0]     tx_idx_q, tx_idx_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [15:0]    dividend_q, dividend_d;
    logic [15:0]    divisor_q, divisor_d;
    logic [15:0]    quot_q, quot_d;
    logic [15:0]    rem_q, rem_d;
    logic           seen_low_q, seen_low_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           tx_valid_q, tx_valid_d;
    logic           div_start_q, div_start_d;
    logic           busy_q, busy_d;
    logic           err_timeout_q, err_timeout_d;
    logic           err_div0_q, err_div0_d;
    logic           rx_overrun_q, rx_overrun_d;
    logic [7:0]     resp_byte;

    // Response byte selected by the transmit index: quotient first, MSB first.
    always_comb begin
        resp_byte = 8'h00;
        case (tx_idx_q)
            3'd0:    resp_byte = quot_q[15:8];
            3'd1:    resp_byte = quot_q[7:0];
            3'd2:    resp_byte = rem_q[15:8];
            3'd3:    resp_byte = rem_q[7:0];
            default: resp_byte = 8'h00;
        endcase
    end

    // Next-state logic for the frame FSM, counters, frame/result registers and pulses.
    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        tx_idx_d      = tx_idx_q;
        timer_d       = timer_q;
        dividend_d    = dividend_q;
        divisor_d     = divisor_q;
        quot_d        = quot_q;
        rem_d         = rem_q;
        seen_low_d    = seen_low_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = 1'b0;
        div_start_d   = 1'b0;
        err_timeout_d = 1'b0;
        err_div0_d    = 1'b0;
        rx_overrun_d  = bus.rx_valid && (state_q != StIdle) && (state_q != StRecv);

        case (state_q)
            StIdle: begin
                tx_idx_d = 3'd0;
                if (bus.rx_valid) begin
                    dividend_d[15:8] = bus.rx_data;
                    byte_cnt_d       = 3'd1;
                    timer_d          = '0;
                    state_d          = StRecv;
                end
            end
            StRecv: begin
                // A byte landing on the expiry cycle wins over the timeout.
                if (bus.rx_valid) begin
                    case (byte_cnt_q)
                        3'd1:    dividend_d[7:0] = bus.rx_data;
                        3'd2:    divisor_d[15:8] = bus.rx_data;
                        3'd3:    divisor_d[7:0]  = bus.rx_data;
                        default: dividend_d[15:8] = bus.rx_data;
                    endcase
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    timer_d    = '0;
                    if (byte_cnt_q == 3'd3) begin
                        state_d = StCheck;
                    end
                end else if (timer_q == RX_LAST) begin
                    err_timeout_d = 1'b1;
                    byte_cnt_d    = 3'd0;
                    timer_d       = '0;
                    state_d       = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StCheck: begin
                byte_cnt_d = 3'd0;
                if (divisor_q == 16'h0000) begin
                    quot_d     = 16'hFFFF;
                    rem_d      = dividend_q;
                    err_div0_d = 1'b1;
                    tx_idx_d   = 3'd0;
                    state_d    = StSend;
                end else begin
                    state_d = StStart;
                end
            end
            StStart: begin
                div_start_d = 1'b1;
                timer_d     = '0;
                state_d     = StWait;
            end
            StWait: begin
                // A result arriving on the expiry cycle is still accepted.
                if (bus.div_done) begin
                    quot_d   = bus.div_quot;
                    rem_d    = bus.div_rem;
                    tx_idx_d = 3'd0;
                    timer_d  = '0;
                    state_d  = StSend;
                end else if (timer_q == DIV_LAST) begin
                    err_timeout_d = 1'b1;
                    timer_d       = '0;
                    state_d       = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StSend: begin
                if (bus.tx_ready) begin
                    tx_data_d  = resp_byte;
                    tx_valid_d = 1'b1;
                    seen_low_d = 1'b0;
                    state_d    = StTxWait;
                end
            end
            StTxWait: begin
                // Byte is done only once ready has dropped and then returned.
                if (!bus.tx_ready) begin
                    seen_low_d = 1'b1;
                end else if (seen_low_q) begin
                    seen_low_d = 1'b0;
                    if (tx_idx_q == 3'd3) begin
                        tx_idx_d = 3'd0;
                        state_d  = StIdle;
                    end else begin
                        tx_idx_d = tx_idx_q + 3'd1;
                        state_d  = StSend;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and output registers; asynchronous reset aborts any frame in flight.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= StIdle;
            byte_cnt_q    <= 3'd0;
            tx_idx_q      <= 3'd0;
            timer_q       <= '0;
            dividend_q    <= 16'h0000;
            divisor_q     <= 16'h0000;
            quot_q        <= 16'h0000;
            rem_q         <= 16'h0000;
            seen_low_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            tx_valid_q    <= 1'b0;
            div_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            err_div0_q    <= 1'b0;
            rx_overrun_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            tx_idx_q      <= tx_idx_d;
            timer_q       <= timer_d;
            dividend_q    <= dividend_d;
            divisor_q     <= divisor_d;
            quot_q        <= quot_d;
            rem_q         <= rem_d;
            seen_low_q    <= seen_low_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            div_start_q   <= div_start_d;
            busy_q        <= busy_d;
            err_timeout_q <= err_timeout_d;
            err_div0_q    <= err_div0_d;
            rx_overrun_q  <= rx_overrun_d;
        end
    end

    assign bus.div_start    = div_start_q;
    assign bus.div_dividend = dividend_q;
    assign bus.div_divisor  = divisor_q;
    assign bus.tx_data      = tx_data_q;
    assign bus.tx_valid     = tx_valid_q;
    assign busy             = busy_q;
    assign err_timeout      = err_timeout_q;
    assign err_div0         = err_div0_q;
    assign rx_overrun       = rx_overrun_q;

endmodule
